// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared constants, state encoding and width helper for the 16-point FFT
// sequencing controller.
//   N_PTS      : points per FFT frame (power of 2)
//   LOG2N      : butterfly stages per frame
//   NUM_FRAMES : frames per run
// ---------------------------------------------------------------------------
package fft_pkg;

   localparam int N_PTS      = 16;
   localparam int LOG2N      = 4;
   localparam int NUM_FRAMES = 64;

   // Width of an index that must hold 0..n-1; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int STG_W  = idx_w(LOG2N);
   localparam int FCNT_W = $clog2(NUM_FRAMES + 1);
   localparam int CYC_W  = 4;   // holds STAGE_CYC-1 for STAGE_CYC up to 15

   typedef enum logic [2:0] {
      IDLE,
      STAGE,
      OUT_RE,
      OUT_IM,
      FIN
   } state_t;

endpackage

// File: rtl/fft_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// fft_seq_ctrl_if
// Bundles the sample strobe and all buffer/engine/output controls of
// fft_seq_ctrl.
//   master : upstream side, drives fir_valid and observes the controls
//   slave  : the controller, receives fir_valid and drives everything else
// ---------------------------------------------------------------------------
interface fft_seq_ctrl_if;
   import fft_pkg::*;

   logic              fir_valid;
   logic              buf_we;
   logic              buf_wbank;
   logic [LOG2N-1:0]  buf_waddr;
   logic              bf_rbank;
   logic              bf_start;
   logic              bf_en;
   logic [STG_W-1:0]  bf_stage;
   logic              out_sel;
   logic              fft_valid;
   logic              done;
   logic [FCNT_W-1:0] frame_cnt;
   logic              overrun;

   modport master (
      output fir_valid,
      input  buf_we, buf_wbank, buf_waddr, bf_rbank, bf_start, bf_en,
             bf_stage, out_sel, fft_valid, done, frame_cnt, overrun
   );

   modport slave (
      input  fir_valid,
      output buf_we, buf_wbank, buf_waddr, bf_rbank, bf_start, bf_en,
             bf_stage, out_sel, fft_valid, done, frame_cnt, overrun
   );
endinterface

// File: rtl/fft_wr_cnt.sv
// ---------------------------------------------------------------------------
// fft_wr_cnt
// Write side of the ping-pong input buffer: sample index counter, bank
// toggle, accepted-frame completion pulse and sticky overrun flag.
//   clk, rst  : clock, asynchronous active-high reset
//   i_valid   : FIR sample present
//   i_done    : run finished, writes are blocked
//   i_pend    : a completed frame is already waiting for the engine
//   o_we      : buffer write strobe (combinational)
//   o_waddr   : sample index within the frame
//   o_wbank   : bank currently being written
//   o_cmp     : accepted frame completion this cycle
//   o_overrun : sticky, a frame completed while one was already waiting
// ---------------------------------------------------------------------------
module fft_wr_cnt
   import fft_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid,
   input  logic             i_done,
   input  logic             i_pend,
   output logic             o_we,
   output logic [LOG2N-1:0] o_waddr,
   output logic             o_wbank,
   output logic             o_cmp,
   output logic             o_overrun
);

   logic [LOG2N-1:0] r_waddr;
   logic             r_wbank;
   logic             r_overrun;
   logic             w_we;
   logic             w_last;
   logic             w_drop;

   assign w_we   = i_valid & ~i_done;
   assign w_last = w_we & (r_waddr == LOG2N'(N_PTS - 1));
   // With a frame already waiting there is no free bank: the new frame is
   // dropped, so the bank is not toggled and will simply be overwritten.
   assign w_drop = w_last & i_pend;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_waddr   <= '0;
         r_wbank   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         // N_PTS is a power of two, so the natural wrap is N_PTS-1 -> 0.
         if (w_we)
            r_waddr <= r_waddr + LOG2N'(1);
         if (w_last && !i_pend)
            r_wbank <= ~r_wbank;
         if (w_drop)
            r_overrun <= 1'b1;
      end
   end

   assign o_we      = w_we;
   assign o_waddr   = r_waddr;
   assign o_wbank   = r_wbank;
   assign o_cmp     = w_last & ~i_pend;
   assign o_overrun = r_overrun;

endmodule

// File: rtl/fft_seq_ctrl.sv
// ---------------------------------------------------------------------------
// fft_seq_ctrl
// Control and scheduling for the 16-point streaming FFT: launches the
// butterfly engine once per completed input frame, steps it through LOG2N
// stages of STAGE_CYC cycles each, then emits a real/imag output pair.
//   clk, rst : clock, asynchronous active-high reset
//   s_bus    : slave side of fft_seq_ctrl_if (fir_valid in, controls out)
// ---------------------------------------------------------------------------
module fft_seq_ctrl
   import fft_pkg::*;
#(
   parameter int STAGE_CYC = 1
)
(
   input  logic           clk,
   input  logic           rst,
   fft_seq_ctrl_if.slave  s_bus
);

   state_t            r_state;
   logic              r_pend;
   logic [CYC_W-1:0]  r_cyc;
   logic              r_bf_rbank;
   logic              r_bf_start;
   logic              r_bf_en;
   logic [STG_W-1:0]  r_bf_stage;
   logic              r_out_sel;
   logic              r_fft_valid;
   logic              r_done;
   logic [FCNT_W-1:0] r_frame_cnt;

   logic              w_we;
   logic [LOG2N-1:0]  w_waddr;
   logic              w_wbank;
   logic              w_cmp;
   logic              w_overrun;

   fft_wr_cnt u_wr_cnt (
      .clk       (clk),
      .rst       (rst),
      .i_valid   (s_bus.fir_valid),
      .i_done    (r_done),
      .i_pend    (r_pend),
      .o_we      (w_we),
      .o_waddr   (w_waddr),
      .o_wbank   (w_wbank),
      .o_cmp     (w_cmp),
      .o_overrun (w_overrun)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_pend      <= 1'b0;
         r_cyc       <= '0;
         r_bf_rbank  <= 1'b0;
         r_bf_start  <= 1'b0;
         r_bf_en     <= 1'b0;
         r_bf_stage  <= '0;
         r_out_sel   <= 1'b0;
         r_fft_valid <= 1'b0;
         r_done      <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         // A frame finishing while the engine is busy waits in pend.
         if (w_cmp && (r_state != IDLE))
            r_pend <= 1'b1;

         case (r_state)
            IDLE: begin
               if (r_pend || w_cmp) begin
                  r_state    <= STAGE;
                  // The waiting frame's bank is the one no longer being
                  // written; a fresh completion reads the bank just filled.
                  r_bf_rbank <= r_pend ? ~w_wbank : w_wbank;
                  r_pend     <= 1'b0;
                  r_bf_start <= 1'b1;
                  r_bf_en    <= 1'b1;
                  r_bf_stage <= '0;
                  r_cyc      <= '0;
               end
            end
            STAGE: begin
               r_bf_start <= 1'b0;
               if (r_cyc == CYC_W'(STAGE_CYC - 1)) begin
                  r_cyc <= '0;
                  if (r_bf_stage == STG_W'(LOG2N - 1)) begin
                     r_state     <= OUT_RE;
                     r_bf_en     <= 1'b0;
                     r_bf_stage  <= '0;
                     r_fft_valid <= 1'b1;
                     r_out_sel   <= 1'b0;
                  end else begin
                     r_bf_stage <= r_bf_stage + STG_W'(1);
                  end
               end else begin
                  r_cyc <= r_cyc + CYC_W'(1);
               end
            end
            OUT_RE: begin
               r_state   <= OUT_IM;
               r_out_sel <= 1'b1;
            end
            OUT_IM: begin
               r_fft_valid <= 1'b0;
               r_out_sel   <= 1'b0;
               r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
               if (r_frame_cnt == FCNT_W'(NUM_FRAMES - 1)) begin
                  r_state <= FIN;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= IDLE;
               end
            end
            FIN: begin
               r_done <= 1'b1;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign s_bus.buf_we    = w_we;
   assign s_bus.buf_wbank = w_wbank;
   assign s_bus.buf_waddr = w_waddr;
   assign s_bus.bf_rbank  = r_bf_rbank;
   assign s_bus.bf_start  = r_bf_start;
   assign s_bus.bf_en     = r_bf_en;
   assign s_bus.bf_stage  = r_bf_stage;
   assign s_bus.out_sel   = r_out_sel;
   assign s_bus.fft_valid = r_fft_valid;
   assign s_bus.done      = r_done;
   assign s_bus.frame_cnt = r_frame_cnt;
   assign s_bus.overrun   = w_overrun;

endmodule
